// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// error causes and a small lane-extension helper.
package lsu_pkg;

  // Access size / signedness encodings (instruction bits 14:12)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ILLEGAL  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } lsu_cause_e;

  // Widen a byte (lane[7:0]) or halfword (lane[15:0]) to 32 bits,
  // replicating the top bit when a signed load is requested.
  function automatic logic [31:0] ext_lane(input logic [15:0] lane,
                                           input logic        is_half,
                                           input logic        is_signed);
    logic sign_bit;
    logic [31:0] result;
    if (is_half) begin
      sign_bit = is_signed & lane[15];
      result   = {{16{sign_bit}}, lane};
    end else begin
      sign_bit = is_signed & lane[7];
      result   = {{24{sign_bit}}, lane[7:0]};
    end
    return result;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit. The request side checks
// legality/alignment and builds byte enables and replicated store data from
// the live decode inputs; the response side extracts and extends load data
// using the operands latched when the request was accepted.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [3:0]  we_in_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic        legal_o,
  output logic        misaligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  be_wide_s;
  logic [7:0]  byte_lane_s;
  logic [15:0] half_lane_s;

  // Legal funct3 set differs for loads and stores; unsigned forms are load-only
  always_comb begin
    legal_o = 1'b0;
    case (funct3_i)
      F3_B, F3_H, F3_W: legal_o = 1'b1;
      F3_BU, F3_HU:     legal_o = ~is_store_i;
      default:          legal_o = 1'b0;
    endcase
  end

  // Halfwords need an even address, words a 4-byte aligned one
  always_comb begin
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_H, F3_HU: misaligned_o = addr_lo_i[0];
      F3_W:        misaligned_o = (addr_lo_i != 2'b00);
      default:     misaligned_o = 1'b0;
    endcase
  end

  // Shift the decode byte-enable pattern into its lane; bits beyond lane 3 fall off
  always_comb begin
    be_wide_s = {4'b0000, we_in_i} << addr_lo_i;
    be_o      = be_wide_s[3:0];
  end

  // Replicate store data so whichever lanes are enabled see the right bytes
  always_comb begin
    wdata_o = wdata_i;
    case (funct3_i)
      F3_B:    wdata_o = {4{wdata_i[7:0]}};
      F3_H:    wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

  // Pick the addressed lane of the returned word and extend it
  always_comb begin
    byte_lane_s = rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
    half_lane_s = rdata_i[{ld_addr_lo_i[1], 4'b0000} +: 16];
    ld_data_o   = rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = ext_lane({8'h00, byte_lane_s}, 1'b0, 1'b1);
      F3_BU:   ld_data_o = ext_lane({8'h00, byte_lane_s}, 1'b0, 1'b0);
      F3_H:    ld_data_o = ext_lane(half_lane_s, 1'b1, 1'b1);
      F3_HU:   ld_data_o = ext_lane(half_lane_s, 1'b1, 1'b0);
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one decoded L/S access into a single handshaked
// data-memory transaction and reports completion, extended load data and
// error causes (misaligned, illegal funct3, memory timeout).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd255,
  parameter int unsigned ADDR_W         = 32'd32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [3:0]        we_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_cause,
  output logic [31:0]       rdata_out,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_we,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; it saturates rather than wraps
  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES < 32'd2) ? 32'd1 : $clog2(TIMEOUT_CYCLES + 32'd1);
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1;
  localparam logic [CNT_W-1:0] TO_LAST  = TO_LAST_I[CNT_W-1:0];
  localparam logic             TO_EN    = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  lsu_state_e        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  lsu_cause_e        cause_q, cause_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [3:0]        dwe_q, dwe_d;
  logic [31:0]       dwdata_q, dwdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        alo_q, alo_d;
  logic              store_q, store_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              legal_s;
  logic              misal_s;
  logic [3:0]        be_s;
  logic [31:0]       wrep_s;
  logic [31:0]       ld_data_s;
  logic              timeout_hit_s;

  lsu_align u_align (
    .funct3_i     (funct3),
    .is_store_i   (is_store),
    .addr_lo_i    (addr[1:0]),
    .we_in_i      (we_in),
    .wdata_i      (wdata),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (alo_q),
    .rdata_i      (dmem_rdata),
    .legal_o      (legal_s),
    .misaligned_o (misal_s),
    .be_o         (be_s),
    .wdata_o      (wrep_s),
    .ld_data_o    (ld_data_s)
  );

  assign timeout_hit_s = TO_EN && (cnt_q == TO_LAST);

  // Next-state and output decode; err/cause are only asserted alongside done
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    daddr_d  = daddr_q;
    dwe_d    = dwe_q;
    dwdata_d = dwdata_q;
    f3_d     = f3_q;
    alo_d    = alo_q;
    store_d  = store_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    cause_d  = CAUSE_NONE;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!legal_s) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (misal_s) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d  = ST_REQ;
            req_d    = 1'b1;
            daddr_d  = {addr[ADDR_W-1:2], 2'b00};
            dwe_d    = is_store ? be_s : 4'b0000;
            dwdata_d = is_store ? wrep_s : 32'h0000_0000;
            f3_d     = funct3;
            alo_d    = addr[1:0];
            store_d  = is_store;
            cnt_d    = {CNT_W{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_ack) begin
          state_d = ST_RESP;
          req_d   = 1'b0;
          if (!store_q) begin
            rdata_d = ld_data_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (timeout_hit_s) begin
          state_d = ST_RESP;
          req_d   = 1'b0;
          err_d   = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1'b1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
    done_d = (state_d == ST_RESP);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cause_q  <= CAUSE_NONE;
      rdata_q  <= 32'h0000_0000;
      req_q    <= 1'b0;
      daddr_q  <= {ADDR_W{1'b0}};
      dwe_q    <= 4'b0000;
      dwdata_q <= 32'h0000_0000;
      f3_q     <= 3'b000;
      alo_q    <= 2'b00;
      store_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cause_q  <= cause_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      daddr_q  <= daddr_d;
      dwe_q    <= dwe_d;
      dwdata_q <= dwdata_d;
      f3_q     <= f3_d;
      alo_q    <= alo_d;
      store_q  <= store_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_cause  = cause_q;
  assign rdata_out  = rdata_q;
  assign dmem_req   = req_q;
  assign dmem_addr  = daddr_q;
  assign dmem_we    = dwe_q;
  assign dmem_wdata = dwdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of instruction decode.
- Consumes the decoded L/S-type fields: funct3, the store byte-enable pattern (an intermediate pattern 0001/0011/1111, not yet lane-shifted) and the effective address from the ALU.
- Converts each access into a single handshaked data-memory transaction with final byte enables and lane-replicated write data.
- Returns sign- or zero-extended load data for register writeback, and reports misalignment, illegal funct3 and memory timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in REQ without dmem_ack before abort; 0 disables the timeout.
- ADDR_W, 32: address width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request from decode/ALU; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  access size/sign (instruction bits 14:12).
- we_in  input  4  intermediate store byte-enable pattern from decode.
- addr  input  ADDR_W  effective address (rs1+imm).
- wdata  input  32  store data (rs2).
- busy  output  1  high in every state other than IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; access failed.
- err_cause  output  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none.
- rdata_out  output  32  extended load data; valid with done when err=0 and the access is a load.
- dmem_req  output  1  memory request, held until ack or abort.
- dmem_addr  output  ADDR_W  word-aligned address, addr with bits [1:0] forced to 0.
- dmem_we  output  4  final byte enables; 0000 for loads.
- dmem_wdata  output  32  lane-replicated store data.
- dmem_ack  input  1  memory completion; read data valid in the same cycle.
- dmem_rdata  input  32  memory read word.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; busy, done, err, dmem_req = 0; err_cause = 00; rdata_out, dmem_addr, dmem_we, dmem_wdata = 0. Reset mid-transaction drops dmem_req at that edge. The memory side must tolerate an abandoned request.
- FSM states IDLE, REQ, RESP:
  - IDLE + start, legal access: latch operands, go to REQ. dmem_req = 1 from the next cycle.
  - IDLE + start, illegal access: go to RESP with err = 1. No memory access is made.
  - REQ: dmem_req, dmem_addr, dmem_we and dmem_wdata stay stable. On dmem_ack: capture and extend read data, go to RESP. Timeout counter reaching TIMEOUT_CYCLES (nonzero): drop req, go to RESP with cause 11.
  - RESP: done = 1 for exactly one cycle, then IDLE.
- Latency: start at cycle 0, ack at cycle k (k ≥ 1) gives done at cycle k+1. An ack in the first REQ cycle is valid. Error path: done at cycle 1.
- start while busy is ignored (no queueing). dmem_ack outside REQ is ignored.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
  - Anything else gives cause 10. Illegal funct3 takes priority over misalignment.
- Misaligned: halfword with addr[0] = 1; word with addr[1:0] ≠ 00.
- Store byte enables: dmem_we = we_in << addr[1:0], truncated to 4 bits.
- Store data: byte → {4{wdata[7:0]}}, half → {2{wdata[15:0]}}, word → wdata.
- Load extraction:
  - Byte lane = dmem_rdata[8*addr[1:0] +: 8].
  - Half lane = dmem_rdata[16*addr[1] +: 16].
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
- rdata_out holds its value until the next successful load; stores leave it unchanged.
- Timeout counter clears on entry to REQ and saturates; it does not wrap.

Decomposition:
- lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, err_cause enum.
- Sub-module lsu_align: purely combinational. Computes store byte enables and replicated data, load lane extraction and extension, and the legal/misaligned checks. The top level holds the FSM, operand latches and timeout counter.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ack 2 cycles after req → dmem_addr=0x100, dmem_we=1111, dmem_wdata=0xDEADBEEF; done 3 cycles after start, err=0.
- SB addr=0x103, wdata=0x000000A5 → dmem_we=1000, dmem_wdata=0xA5A5A5A5.
- LB addr=0x202, dmem_rdata=0x0080FF11 → rdata_out=0xFFFFFF80. LBU, same inputs → 0x00000080. LH addr=0x202 → 0x00000080. LHU addr=0x200 → 0x0000FF11.
- LW addr=0x101 → no dmem_req; done at cycle 1 with err=1, cause 01. funct3=011 load → cause 10.
- TIMEOUT_CYCLES=4, no ack → dmem_req drops after 4 REQ cycles; done with cause 11. A second start during busy is ignored, and busy is never deasserted early.
- rst_n=0 while in REQ → next cycle dmem_req=0, busy=0, done=0; a subsequent SW completes normally.
